// File: rtl/dsp_replay_deframe.sv
// dsp_replay_deframe
// Pulls header + payload words from a first-word-fall-through FIFO, validates
// the header (magic and length) and replays each frame as an AXI4-Stream
// packet through a single registered output stage. It also counts completed
// frames (wrapping) and rejected headers (saturating).

module dsp_replay_deframe #(
  parameter logic [47:0] HDR_MAGIC = 48'hFB5555555555,
  parameter logic [15:0] MAX_LEN   = 16'd9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active_i,
  input  logic [63:0] fifo_dout_i,
  input  logic        fifo_empty_i,
  output logic        fifo_rd_en_o,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] pkt_cnt_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HUNT,
    S_PAYLOAD
  } state_t;

  state_t      state;
  logic [13:0] beats_left;  // payload words still to pop for this frame
  logic [2:0]  rem;         // bytes used in the final word; 0 means all 8

  // The output register can take a new beat when it is empty or draining now.
  logic        out_free;
  logic [16:0] hdr_len;
  logic [13:0] hdr_beats;
  logic        hdr_magic_ok;
  logic        hdr_len_ok;
  logic [7:0]  last_keep;

  assign out_free     = ~m_axis_tvalid | m_axis_tready;
  // Length is widened to 17 bits so the round-up add cannot overflow.
  assign hdr_len      = {1'b0, fifo_dout_i[15:0]};
  assign hdr_beats    = 14'((hdr_len + 17'd7) >> 3);
  assign hdr_magic_ok = (fifo_dout_i[63:16] == HDR_MAGIC);
  assign hdr_len_ok   = (hdr_len != 17'd0) && (hdr_len <= {1'b0, MAX_LEN});

  // Keep mask for the final beat: bytes fill from tkeep[7] downwards.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    last_keep = 8'hFF;
    if (rem != 3'd0) begin
      last_keep = 8'hFF << (4'd8 - {1'b0, rem});
    end
  end

  // Pop request: headers only while enabled, payload regardless of enable;
  // never while the FIFO is empty or the output still holds a stalled beat.
  always_comb begin
    fifo_rd_en_o = 1'b0;
    unique case (state)
      S_HUNT:    fifo_rd_en_o = active_i & ~fifo_empty_i & out_free;
      S_PAYLOAD: fifo_rd_en_o = ~fifo_empty_i & out_free;
      default:   fifo_rd_en_o = 1'b0;
    endcase
  end

  // Frame FSM, output register stage and counters.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order.
    if (rst) begin
      state         <= S_IDLE;
      beats_left    <= '0;
      rem           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
      pkt_cnt_o     <= '0;
      err_cnt_o     <= '0;
    end else begin
      // A handshake empties the stage unless a pop below refills it.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
        if (m_axis_tlast) begin
          pkt_cnt_o <= pkt_cnt_o + 32'd1;
        end
      end

      unique case (state)
        S_IDLE: begin
          if (active_i) begin
            state <= S_HUNT;
          end
        end

        S_HUNT: begin
          if (!active_i) begin
            state <= S_IDLE;
          end else if (fifo_rd_en_o && hdr_magic_ok) begin
            if (hdr_len_ok) begin
              beats_left <= hdr_beats;
              rem        <= fifo_dout_i[2:0];
              state      <= S_PAYLOAD;
            end else if (err_cnt_o != 16'hFFFF) begin
              err_cnt_o <= err_cnt_o + 16'd1;
            end
          end
          // Non-magic words are popped and dropped while resynchronising.
        end

        S_PAYLOAD: begin
          if (fifo_rd_en_o) begin
            m_axis_tdata  <= fifo_dout_i;
            m_axis_tvalid <= 1'b1;
            beats_left    <= beats_left - 14'd1;
            if (beats_left == 14'd1) begin
              m_axis_tlast <= 1'b1;
              m_axis_tkeep <= last_keep;
              state        <= active_i ? S_HUNT : S_IDLE;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tkeep <= 8'hFF;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
